// File: rtl/reservoir_input_driver.sv
// Reservoir input driver: accepts one sample per DFR time step over a
// valid/ready handshake, multiplies it by a per-virtual-node mask and issues
// one saturated update per node to the reservoir (res_en / res_din / res_valid).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   sample_valid/ready  upstream handshake; sample_ready = state is IDLE
//   sample_data         input sample, captured on the handshake cycle only
//   mask_wr_en/addr/data mask table write port (out-of-range addresses ignored)
//   res_en              one-cycle update request to the reservoir
//   res_din             masked value, held until the next capture
//   res_valid           reservoir ready; only consulted in WAIT
//   node_idx            virtual node currently being driven
//   busy                sample in progress
//   sample_done         one-cycle pulse after the last node update
module reservoir_input_driver #(
    parameter int unsigned VIRTUAL_NODES = 10,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned MASK_WIDTH    = 16,
    parameter int unsigned MASK_FRAC     = 15,
    parameter int unsigned ADDR_WIDTH    = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    input  logic [DATA_WIDTH-1:0] sample_data,
    input  logic                  mask_wr_en,
    input  logic [ADDR_WIDTH-1:0] mask_wr_addr,
    input  logic [MASK_WIDTH-1:0] mask_wr_data,
    output logic                  res_en,
    output logic [DATA_WIDTH-1:0] res_din,
    input  logic                  res_valid,
    output logic [ADDR_WIDTH-1:0] node_idx,
    output logic                  busy,
    output logic                  sample_done
);

    localparam int unsigned PROD_WIDTH = DATA_WIDTH + MASK_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_HOLD   = 2'd2,
        ST_SETTLE = 2'd3
    } state_t;

    state_t                  state, state_d;
    logic [DATA_WIDTH-1:0]   sample_q, sample_d;
    logic [ADDR_WIDTH-1:0]   node_d;
    logic [DATA_WIDTH-1:0]   res_din_d;
    logic                    res_en_d, busy_d, done_d;
    logic [MASK_WIDTH-1:0]   mask_mem [VIRTUAL_NODES];
    logic [MASK_WIDTH-1:0]   mask_rd;
    logic [PROD_WIDTH-1:0]   product_full, product_shift;
    logic [DATA_WIDTH-1:0]   product_sat;
    logic                    last_node;

    assign sample_ready = (state == ST_IDLE);
    assign last_node    = (node_idx == ADDR_WIDTH'(VIRTUAL_NODES - 1));

    // Mask table; a write coinciding with a capture lands after it, so the old value is used
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(VIRTUAL_NODES); i++) begin
                mask_mem[i] <= '0;
            end
        end else if (mask_wr_en && (32'(mask_wr_addr) < VIRTUAL_NODES)) begin
            mask_mem[mask_wr_addr] <= mask_wr_data;
        end
    end

    // Fixed-point multiply with saturation on any overflow above DATA_WIDTH
    assign mask_rd       = mask_mem[node_idx];
    assign product_full  = PROD_WIDTH'(sample_q) * PROD_WIDTH'(mask_rd);
    assign product_shift = product_full >> MASK_FRAC;
    assign product_sat   = (|product_shift[PROD_WIDTH-1:DATA_WIDTH]) ? '1
                                                                      : product_shift[DATA_WIDTH-1:0];

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            sample_q    <= '0;
            node_idx    <= '0;
            res_en      <= 1'b0;
            res_din     <= '0;
            busy        <= 1'b0;
            sample_done <= 1'b0;
        end else begin
            state       <= state_d;
            sample_q    <= sample_d;
            node_idx    <= node_d;
            res_en      <= res_en_d;
            res_din     <= res_din_d;
            busy        <= busy_d;
            sample_done <= done_d;
        end
    end

    // Next-state logic; res_en is only ever a registered function of res_valid
    always_comb begin
        state_d   = state;
        sample_d  = sample_q;
        node_d    = node_idx;
        res_en_d  = 1'b0;
        res_din_d = res_din;
        busy_d    = busy;
        done_d    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample_valid && sample_ready) begin
                    sample_d = sample_data;
                    node_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (res_valid) begin
                    res_din_d = product_sat;
                    res_en_d  = 1'b1;
                    state_d   = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Reservoir captures res_din this cycle; res_valid is not consulted
                if (last_node) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    node_d  = node_idx + ADDR_WIDTH'(1);
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reservoir_input_driver.sv
// Self-checking bench for reservoir_input_driver: table of uniform-mask
// vectors plus directed sequences for stall, mask-write collision,
// back-to-back samples and mid-operation reset.
module tb_reservoir_input_driver;

    localparam int N = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic [31:0] sample_data = '0;
    logic        mask_wr_en = 1'b0;
    logic [3:0]  mask_wr_addr = '0;
    logic [15:0] mask_wr_data = '0;
    logic        res_en;
    logic [31:0] res_din;
    logic        res_valid = 1'b1;
    logic [3:0]  node_idx;
    logic        busy;
    logic        sample_done;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_din [N];

    typedef struct {
        logic [31:0] sample;
        logic [15:0] mask;
        logic [31:0] expect_din;
    } vec_t;

    vec_t vecs [9];

    reservoir_input_driver dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sample_data  (sample_data),
        .mask_wr_en   (mask_wr_en),
        .mask_wr_addr (mask_wr_addr),
        .mask_wr_data (mask_wr_data),
        .res_en       (res_en),
        .res_din      (res_din),
        .res_valid    (res_valid),
        .node_idx     (node_idx),
        .busy         (busy),
        .sample_done  (sample_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic write_mask(input int addr, input logic [15:0] data);
        mask_wr_en   = 1'b1;
        mask_wr_addr = 4'(addr);
        mask_wr_data = data;
        step();
        mask_wr_en   = 1'b0;
    endtask

    task automatic fill_masks(input logic [15:0] data);
        for (int i = 0; i < N; i++) write_mask(i, data);
    endtask

    task automatic fill_exp(input logic [31:0] v);
        for (int i = 0; i < N; i++) exp_din[i] = v;
    endtask

    // Runs one sample from handshake through sample_done, checking every cycle.
    // sn/sl: stall res_valid for sl cycles in WAIT of node sn (sn<0: none).
    // wn: write mask[wn]=0 on the capture edge of node wn (wn<0: none).
    task automatic run_sample(input logic [31:0] s, input bit hold_valid, input logic [31:0] next_s,
                              input int sn, input int sl, input int wn);
        int  ext;
        int  done_cyc;
        bit  pulse;
        int  pk;
        ext      = (sn >= 0) ? sl : 0;
        done_cyc = 3 * N + 1 + ext;
        sample_valid = 1'b1;
        sample_data  = s;
        check("ready_at_accept", 32'(sample_ready), 32'd1);
        step();
        if (hold_valid) begin
            sample_data = next_s;
        end else begin
            sample_valid = 1'b0;
            sample_data  = 32'hDEAD_BEEF;
        end
        for (int cyc = 1; cyc <= done_cyc; cyc++) begin
            res_valid    = !(sn >= 0 && cyc >= 1 + 3 * sn && cyc < 1 + 3 * sn + sl);
            mask_wr_en   = (wn >= 0 && cyc == 1 + 3 * wn);
            mask_wr_addr = 4'(wn);
            mask_wr_data = 16'h0000;
            pulse = 1'b0;
            pk    = 0;
            for (int k = 0; k < N; k++) begin
                if (cyc == 2 + 3 * k + ((sn >= 0 && k >= sn) ? sl : 0)) begin
                    pulse = 1'b1;
                    pk    = k;
                end
            end
            check("res_en", 32'(res_en), 32'(pulse));
            check("sample_done", 32'(sample_done), 32'(cyc == done_cyc));
            check("sample_ready", 32'(sample_ready), 32'(cyc == done_cyc));
            check("busy", 32'(busy), 32'(cyc != done_cyc));
            if (pulse) begin
                check("res_din", res_din, exp_din[pk]);
                check("node_idx", 32'(node_idx), 32'(pk));
            end
            if (!res_valid && sn > 0) begin
                check("res_din_stall_hold", res_din, exp_din[sn-1]);
            end
            if (cyc < done_cyc) step();
        end
        mask_wr_en = 1'b0;
        res_valid  = 1'b1;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0100, 16'h8000, 32'h0000_0100};
        vecs[1] = '{32'hFFFF_FFFF, 16'hFFFF, 32'hFFFF_FFFF};
        vecs[2] = '{32'h0000_1000, 16'h4000, 32'h0000_0800};
        vecs[3] = '{32'h1234_5678, 16'h0000, 32'h0000_0000};
        vecs[4] = '{32'h8000_0000, 16'h8000, 32'h8000_0000};
        vecs[5] = '{32'h8000_0000, 16'h8001, 32'h8001_0000};
        vecs[6] = '{32'h8000_0000, 16'hFFFF, 32'hFFFF_0000};
        vecs[7] = '{32'hFFFF_FFFF, 16'h8001, 32'hFFFF_FFFF};
        vecs[8] = '{32'h0000_0003, 16'h4000, 32'h0000_0001};

        // Reset values
        step();
        step();
        check("rst_ready", 32'(sample_ready), 32'd1);
        check("rst_res_en", 32'(res_en), 32'd0);
        check("rst_res_din", res_din, 32'd0);
        check("rst_node_idx", 32'(node_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(sample_done), 32'd0);
        rst = 1'b0;
        step();

        // Uniform-mask vectors
        for (int v = 0; v < 9; v++) begin
            fill_masks(vecs[v].mask);
            fill_exp(vecs[v].expect_din);
            run_sample(vecs[v].sample, 1'b0, 32'd0, -1, 0, -1);
        end

        // Per-node masks, plus out-of-range writes that must be ignored
        fill_masks(16'h8000);
        write_mask(3, 16'h4000);
        write_mask(7, 16'h0000);
        write_mask(10, 16'h0000);
        write_mask(15, 16'h0000);
        fill_exp(32'h0000_1000);
        exp_din[3] = 32'h0000_0800;
        exp_din[7] = 32'h0000_0000;
        run_sample(32'h0000_1000, 1'b0, 32'd0, -1, 0, -1);

        // res_valid low for 5 cycles in WAIT of node 4
        fill_masks(16'h8000);
        fill_exp(32'h0000_0100);
        run_sample(32'h0000_0100, 1'b0, 32'd0, 4, 5, -1);

        // Mask write on the same edge as node 2 capture: old value used
        fill_exp(32'h0000_0100);
        run_sample(32'h0000_0100, 1'b0, 32'd0, -1, 0, 2);

        // Back-to-back with sample_valid held; mask[2] is now 0
        fill_exp(32'h0000_0200);
        exp_din[2] = 32'h0;
        run_sample(32'h0000_0200, 1'b1, 32'h0000_0300, -1, 0, -1);
        fill_exp(32'h0000_0300);
        exp_din[2] = 32'h0;
        run_sample(32'h0000_0300, 1'b0, 32'd0, -1, 0, -1);

        // Reset asserted during HOLD of node 6
        sample_valid = 1'b1;
        sample_data  = 32'h0000_0100;
        step();
        sample_valid = 1'b0;
        for (int c = 1; c < 20; c++) step();
        check("pre_rst_res_en", 32'(res_en), 32'd1);
        check("pre_rst_node", 32'(node_idx), 32'd6);
        rst = 1'b1;
        #1;
        check("midrst_res_en", 32'(res_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_node", 32'(node_idx), 32'd0);
        check("midrst_ready", 32'(sample_ready), 32'd1);
        step();
        rst = 1'b0;
        step();
        fill_exp(32'h0);
        run_sample(32'h0000_0100, 1'b0, 32'd0, -1, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reservoir_input_driver.md
Name: reservoir_input_driver

Overview:
- Transmit side of the reservoir update interface (en / din / reservoir_valid).
- Accepts one input sample per DFR time step from upstream via a valid/ready handshake.
- Multiplies the sample by a programmable per-virtual-node mask and issues VIRTUAL_NODES masked values to the reservoir, one update per node.
- Sits between the sample source (DMA/ADC path) and the reservoir.

Parameters:
VIRTUAL_NODES, 10, number of mask entries and reservoir updates per sample
DATA_WIDTH, 32, sample and reservoir data width (unsigned)
MASK_WIDTH, 16, mask entry width (unsigned fixed point)
MASK_FRAC, 15, fractional bits of mask (0x8000 = 1.0 at defaults)
ADDR_WIDTH, $clog2(VIRTUAL_NODES), mask address / node index width

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
sample_valid  in  1  upstream sample present
sample_ready  out  1  driver can accept a sample
sample_data  in  DATA_WIDTH  input sample
mask_wr_en  in  1  mask write strobe
mask_wr_addr  in  ADDR_WIDTH  mask entry index
mask_wr_data  in  MASK_WIDTH  mask value
res_en  out  1  reservoir update request (one-cycle pulse)
res_din  out  DATA_WIDTH  masked value to reservoir
res_valid  in  1  reservoir idle/ready (reservoir_valid)
node_idx  out  ADDR_WIDTH  node currently being driven
busy  out  1  sample in progress
sample_done  out  1  one-cycle pulse after last node update

Behaviour:
- Interface decision: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: state=IDLE, res_en=0, res_din=0, node_idx=0, busy=0, sample_done=0, all mask entries=0, sample latch=0.
- Reset asserted mid-operation: res_en drops immediately, state returns to IDLE, the partial sample is discarded.
- Outputs: res_en, res_din, node_idx, busy and sample_done are registered. sample_ready = (state==IDLE), combinational from state only; it is 1 during and after reset.
- res_en never depends combinationally on res_valid. This is required because the reservoir's valid output is a combinational function of en.
- Multiply: product = (sample * mask[node_idx]) >> MASK_FRAC, full width DATA_WIDTH+MASK_WIDTH.
- Saturation: if any product bit at or above DATA_WIDTH is set, res_din = all ones; otherwise res_din = the low DATA_WIDTH bits.
- State machine:
  - IDLE: on sample_valid&&sample_ready, latch sample_data, node_idx<=0, busy<=1, go to WAIT.
  - WAIT: when res_valid==1, res_din<=product, res_en<=1, go to HOLD. Otherwise remain in WAIT indefinitely, with no timeout.
  - HOLD (res_en=1 this cycle): res_en<=0, go to SETTLE.
  - SETTLE (reservoir captures this cycle): res_valid is ignored.
    - If node_idx==VIRTUAL_NODES-1: sample_done<=1, busy<=0, go to IDLE.
    - Otherwise: node_idx++, go to WAIT.
- res_din is held stable from HOLD until the next WAIT→HOLD transition. The reservoir sees it unchanged through its capture cycle.
- Timing with res_valid continuously 1 and sample accepted at edge t:
  - res_en high in cycles t+2+3k, for k=0..VIRTUAL_NODES-1.
  - sample_done high in cycle t+3·VIRTUAL_NODES+1; sample_ready is 1 that same cycle.
  - Throughput: 3 cycles per node.
- Mask writes:
  - Accepted in any state; take effect on the next edge.
  - A write in the same cycle as the WAIT→HOLD product capture for the same address: the old value is used.
  - mask_wr_addr ≥ VIRTUAL_NODES: the write is ignored.
- Upstream: sample_valid while not ready is held off and not lost. sample_data is only sampled on the handshake cycle.
- sample_done and a new acceptance can occur in the same cycle; back-to-back samples need no idle gap.

Test Plan:
- Reset then program mask[k]=0x8000 for all k, send sample 0x00000100 → 10 res_en pulses at t+2,5,…,29, each with res_din=0x00000100, node_idx 0..9; sample_done at t+31.
- mask[3]=0x4000, mask[7]=0x0000, others 0x8000, sample 0x00001000 → res_din 0x800 at node 3, 0x0 at node 7, 0x1000 elsewhere.
- Sample 0xFFFFFFFF with mask 0xFFFF → res_din=0xFFFFFFFF (saturated) on every node.
- Hold res_valid=0 for 5 cycles at node 4 → driver stays in WAIT with res_en=0 and res_din unchanged; pulse resumes the cycle after res_valid returns to 1; total cycle count extends by 5.
- Assert rst during HOLD of node 6 → res_en=0 the same cycle, busy=0, mask reads 0; the next sample restarts at node_idx=0.
- Two samples back to back with sample_valid held high → second accepted on the sample_done cycle; first res_en of the second sample 2 cycles later; sample_ready low throughout both runs otherwise.
